// File: rtl/hv_mem_pkg.sv
// rtl/hv_mem_pkg.sv - shared widths, types and fill FSM states for the hypervector memory responder
package hv_mem_pkg;

  localparam int ADDR_WIDTH_DEF = 21;
  localparam int DATA_WIDTH_DEF = 32;

  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/hv_mem_responder_core.sv
// rtl/hv_mem_responder_core.sv - hv_dpram_core: 1-write/1-read synchronous array, read-first, registered read
module hv_dpram_core #(
  parameter int IDX_W      = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Storage carries no reset so it can map onto block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/hv_mem_responder.sv
// rtl/hv_mem_responder.sv - kernel memory responder with fill engine; HV_MEM_BYPASS_EN selects write-first reads
module hv_mem_responder
  import hv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we_n,
  input  logic [ADDR_WIDTH-1:0] waddress,
  input  logic [DATA_WIDTH-1:0] data_wr,
  input  logic [ADDR_WIDTH-1:0] raddress,
  output logic [DATA_WIDTH-1:0] data_rd,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH-1:0] fill_len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  ready,
  output logic                  fill_done
);

  // DEPTH is a power of two, so address modulo DEPTH is just the low index bits.
  localparam int IDX_W = $clog2(DEPTH);

  fill_state_t           state_q, state_d;
  logic [IDX_W-1:0]      cur_q;
  logic [ADDR_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] val_q;
  logic                  load;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^{waddress[ADDR_WIDTH-1:IDX_W], raddress[ADDR_WIDTH-1:IDX_W],
                            fill_base[ADDR_WIDTH-1:IDX_W]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b1;
    fill_done = 1'b0;
    load      = 1'b0;
    mem_we    = !we_n;
    mem_waddr = waddress[IDX_W-1:0];
    mem_wdata = data_wr;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          load    = (fill_len != '0);
          state_d = (fill_len != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        // The fill engine owns the single write port; kernel writes are dropped.
        ready     = 1'b0;
        mem_we    = 1'b1;
        mem_waddr = cur_q;
        mem_wdata = val_q;
        if (rem_q == ADDR_WIDTH'(1)) state_d = DONE;
      end
      DONE: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q <= '0;
      rem_q <= '0;
      val_q <= '0;
    end else if (load) begin
      cur_q <= fill_base[IDX_W-1:0];
      rem_q <= fill_len;
      val_q <= fill_value;
    end else if (state_q == FILL) begin
      cur_q <= cur_q + IDX_W'(1);
      rem_q <= rem_q - ADDR_WIDTH'(1);
    end
  end

  hv_dpram_core #(
    .IDX_W      (IDX_W),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (raddress[IDX_W-1:0]),
    .rdata (core_rdata)
  );

`ifdef HV_MEM_BYPASS_EN
  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= mem_we && (mem_waddr == raddress[IDX_W-1:0]);
      fwd_data_q <= mem_wdata;
    end
  end

  assign data_rd = fwd_q ? fwd_data_q : core_rdata;
`else
  assign data_rd = core_rdata;
`endif

endmodule

// File: tb/tb_hv_mem_responder.sv
// tb/tb_hv_mem_responder.sv - scoreboard bench for hv_mem_responder against a queue-based memory model
module tb_hv_mem_responder;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        we_n = 1'b1;
  logic [20:0] waddress = '0;
  logic [31:0] data_wr = '0;
  logic [20:0] raddress = '0;
  logic [31:0] data_rd;
  logic        fill_start = 1'b0;
  logic [20:0] fill_base = '0;
  logic [20:0] fill_len = '0;
  logic [31:0] fill_value = '0;
  logic        ready;
  logic        fill_done;

  hv_mem_responder dut (
    .clk(clk), .reset_n(reset_n), .we_n(we_n), .waddress(waddress), .data_wr(data_wr),
    .raddress(raddress), .data_rd(data_rd), .fill_start(fill_start), .fill_base(fill_base),
    .fill_len(fill_len), .fill_value(fill_value), .ready(ready), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct { bit known; logic [31:0] data; bit rdy; bit done; } exp_t;
  typedef struct { int a; logic [31:0] v; } wr_t;

  exp_t        exp_q[$];
  wr_t         pend[$];
  logic [31:0] mdl[int];
  bit          in_done;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: a fill is a list of L pending word writes consumed one per edge.
  function automatic void model_step();
    exp_t        e;
    wr_t         w;
    bit          wr = 0;
    bit          done_n = 0;
    int          wa = 0;
    logic [31:0] wd = '0;
    int          ra = int'(raddress) % DEPTH;
    e.known = mdl.exists(ra);
    e.data  = e.known ? mdl[ra] : '0;
    if (pend.size() != 0) begin
      w = pend.pop_front();
      wr = 1; wa = w.a; wd = w.v;
      if (pend.size() == 0) done_n = 1;
    end else begin
      if (!we_n) begin wr = 1; wa = int'(waddress) % DEPTH; wd = data_wr; end
      if (fill_start && !in_done) begin
        if (fill_len == 0) done_n = 1;
        else for (int k = 0; k < int'(fill_len); k++) begin
          w.a = (int'(fill_base) + k) % DEPTH; w.v = fill_value; pend.push_back(w);
        end
      end
    end
`ifdef HV_MEM_BYPASS_EN
    if (wr && wa == ra) begin e.known = 1; e.data = wd; end
`endif
    if (wr) mdl[wa] = wd;
    in_done = done_n;
    e.rdy   = (pend.size() == 0);
    e.done  = done_n;
    exp_q.push_back(e);
  endfunction

  task automatic drive(input logic wn, input int wa, input logic [31:0] wd, input int ra,
                       input logic fs, input int fb, input int fl, input logic [31:0] fv);
    @(negedge clk); #1;
    we_n = wn; waddress = wa[20:0]; data_wr = wd; raddress = ra[20:0];
    fill_start = fs; fill_base = fb[20:0]; fill_len = fl[20:0]; fill_value = fv;
    model_step();
  endtask

  task automatic rd(input int ra);
    drive(1'b1, 0, 32'h0, ra, 1'b0, 0, 0, 32'h0);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    drive(1'b0, a, d, 0, 1'b0, 0, 0, 32'h0);
  endtask

  task automatic fill(input int b, input int l, input logic [31:0] v);
    drive(1'b1, 0, 32'h0, 0, 1'b1, b, l, v);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset_n = 0;
    exp_q.delete(); pend.delete(); in_done = 0;
    #1;
    chk("reset data_rd", data_rd, 32'h0);
    chk("reset ready", {31'b0, ready}, 32'h1);
    chk("reset fill_done", {31'b0, fill_done}, 32'h0);
    @(negedge clk); #1;
    reset_n = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.known) chk("data_rd", data_rd, e.data);
        chk("ready", {31'b0, ready}, {31'b0, e.rdy});
        chk("fill_done", {31'b0, fill_done}, {31'b0, e.done});
      end
    end
  end

  initial begin : stim
    in_done = 0;
    #2;
    chk("reset data_rd", data_rd, 32'h0);
    chk("reset ready", {31'b0, ready}, 32'h1);
    chk("reset fill_done", {31'b0, fill_done}, 32'h0);
    @(negedge clk); #1;
    reset_n = 1;

    // Fill 0..999 with 25, address 1000 pre-written with 7
    wr(1000, 32'd7);
    fill(0, 1000, 32'd25);
    for (int i = 0; i < 1000; i++) rd($urandom_range(0, 1000));
    rd(0); rd(0);
    for (int i = 0; i <= 1000; i++) rd(i);

    wr(1024, 32'hDEADBEEF);
    rd(1024); rd(1024);

    // Same-cycle read/write at address 5
    wr(5, 32'd3);
    drive(1'b0, 5, 32'd9, 5, 1'b0, 0, 0, 32'h0);
    rd(5); rd(5);

    // Wrap-around fill, address 2 must survive
    wr(2, 32'h22);
    fill(DEPTH - 2, 4, 32'h11);
    for (int i = 0; i < 5; i++) rd(DEPTH - 2);
    rd(DEPTH - 1); rd(0); rd(1); rd(2); rd(2);

    // Kernel write and second fill_start during a fill are both dropped
    fill(200, 10, 32'h33);
    rd(3); rd(3);
    drive(1'b0, 3, 32'hBAD, 3, 1'b1, 300, 5, 32'h44);
    for (int i = 0; i < 10; i++) rd(3);
    rd(300); rd(300);

    // fill_start during DONE is ignored; zero-length fill goes straight to DONE
    fill(400, 2, 32'h55);
    rd(400); rd(401);
    fill(500, 3, 32'h66);
    rd(500); rd(500);
    fill(600, 0, 32'h77);
    rd(600); rd(600);

    // Reset in the middle of a fill
    for (int i = 100; i < 110; i++) wr(i, 32'h1000 + i);
    fill(100, 10, 32'hAA);
    for (int i = 0; i < 4; i++) rd(104);
    do_reset();
    for (int i = 100; i < 110; i++) rd(i);
    rd(109);

    // Randomised traffic on a small window with high address bits sprinkled in
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 99);
      int hi = ($urandom_range(0, 3) == 0) ? 32'h1000 * $urandom_range(1, 15) : 0;
      if (r < 4)
        fill(($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : DEPTH - $urandom_range(1, 8),
             $urandom_range(0, 20), $urandom);
      else
        drive(($urandom_range(0, 1) == 1), $urandom_range(0, 63) + hi, $urandom,
              $urandom_range(0, 63) + hi, 1'b0, 0, 0, 32'h0);
    end

    // Fill longer than DEPTH rewrites words; final contents all equal
    fill(10, DEPTH + 3, 32'h5A5A5A5A);
    for (int i = 0; i < DEPTH + 4; i++) rd($urandom_range(0, DEPTH - 1));
    for (int i = 0; i < 40; i++) rd($urandom_range(0, DEPTH - 1));

    rd(0); rd(0);
    @(negedge clk); @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
